// File: rtl/alu_issue_stage_if.sv
// Instruction handshake plus the operand/result bus to the downstream ALU.
interface alu_issue_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic [15:0]      instr_in;
  logic             instr_valid_in;
  logic             instr_ready_out;
  logic [3:0]       op_code_out;
  logic [WIDTH-1:0] rs1_out;
  logic [WIDTH-1:0] rs2_out;
  logic             cin_out;
  logic             bin_out;
  logic             alu_valid_out;
  logic [WIDTH-1:0] result_in;

  modport master (
    output instr_in, instr_valid_in, result_in,
    input  instr_ready_out, op_code_out, rs1_out, rs2_out, cin_out, bin_out, alu_valid_out
  );

  modport slave (
    input  instr_in, instr_valid_in, result_in,
    output instr_ready_out, op_code_out, rs1_out, rs2_out, cin_out, bin_out, alu_valid_out
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: register file, operand fetch for the ALU, LDI/HALT handled locally,
// and writeback of the ALU result one edge after issue.
module alu_issue_stage #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave bus_io,
  output logic             wb_valid_out,
  output logic [2:0]       wb_addr_out,
  output logic [WIDTH-1:0] wb_data_out,
  output logic             halted_out,
  input  logic [2:0]       dbg_addr_in,
  output logic [WIDTH-1:0] dbg_data_out
);

  typedef enum logic [1:0] {StIdle, StExec, StLdiWb, StHalt} state_e;

  localparam logic [3:0] OpLdi  = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [3:0]       op_code_q, op_code_d;
  logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic             cin_q, cin_d, bin_q, bin_d;
  logic [2:0]       rd_q, rd_d;
  logic [8:0]       imm_q, imm_d;
  logic             wb_valid_q, wb_valid_d;
  logic [2:0]       wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             rf_we;
  logic [WIDTH-1:0] rf_wdata;
  logic [3:0]       op;

  assign op = bus_io.instr_in[15:12];

  always_comb begin
    state_d    = state_q;
    op_code_d  = op_code_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    cin_d      = cin_q;
    bin_d      = bin_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.instr_valid_in) begin
          rd_d  = bus_io.instr_in[11:9];
          imm_d = bus_io.instr_in[8:0];
          if (op == OpLdi) begin
            state_d = StLdiWb;
          end else if (op == OpHalt) begin
            state_d = StHalt;
          end else begin
            op_code_d = op;
            rs1_d     = rf_q[bus_io.instr_in[8:6]];
            rs2_d     = rf_q[bus_io.instr_in[5:3]];
            cin_d     = bus_io.instr_in[2];
            bin_d     = bus_io.instr_in[1];
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        rf_we    = 1'b1;
        rf_wdata = bus_io.result_in;
        state_d  = StIdle;
      end
      StLdiWb: begin
        rf_we    = 1'b1;
        rf_wdata = {{(WIDTH-9){1'b0}}, imm_q};
        state_d  = StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (rf_we) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = rd_q;
      wb_data_d  = rf_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_code_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      cin_q      <= 1'b0;
      bin_q      <= 1'b0;
      rd_q       <= '0;
      imm_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_code_q  <= op_code_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      cin_q      <= cin_d;
      bin_q      <= bin_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      // r0 is hardwired to zero: writes still report on the wb port but never land.
      if (rf_we && rd_q != 3'd0) rf_q[rd_q] <= rf_wdata;
    end
  end

  assign bus_io.instr_ready_out = (state_q == StIdle);
  assign bus_io.op_code_out     = op_code_q;
  assign bus_io.rs1_out         = rs1_q;
  assign bus_io.rs2_out         = rs2_q;
  assign bus_io.cin_out         = cin_q;
  assign bus_io.bin_out         = bin_q;
  assign bus_io.alu_valid_out   = (state_q == StExec);
  assign halted_out             = (state_q == StHalt);
  assign wb_valid_out           = wb_valid_q;
  assign wb_addr_out            = wb_addr_q;
  assign wb_data_out            = wb_data_q;
  assign dbg_data_out           = (dbg_addr_in == 3'd0) ? '0 : rf_q[dbg_addr_in];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: LDI, ALU issue/writeback, r0, back-to-back, HALT, reset.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid_out;
  logic [2:0]  wb_addr_out;
  logic [15:0] wb_data_out;
  logic        halted_out;
  logic [2:0]  dbg_addr_in = 3'd0;
  logic [15:0] dbg_data_out;
  int          errors = 0;
  int          checks = 0;

  alu_issue_stage_if #(.WIDTH(16)) bus ();

  alu_issue_stage #(.NREGS(8), .WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_io       (bus),
    .wb_valid_out (wb_valid_out),
    .wb_addr_out  (wb_addr_out),
    .wb_data_out  (wb_data_out),
    .halted_out   (halted_out),
    .dbg_addr_in  (dbg_addr_in),
    .dbg_data_out (dbg_data_out)
  );

  always #10 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr_in = a;
    #1;
    chk(tag, dbg_data_out, exp);
  endtask

  task automatic issue_ldi(input logic [15:0] w);
    bus.instr_in       = w;
    bus.instr_valid_in = 1'b1;
    step();
    bus.instr_valid_in = 1'b0;
    chk("ldi_ready_low", {15'd0, bus.instr_ready_out}, 16'd0);
    step();
  endtask

  initial begin
    bus.instr_in       = '0;
    bus.instr_valid_in = 1'b0;
    bus.result_in      = '0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1 clk_en = 1'b1;
    chk("por_ready", {15'd0, bus.instr_ready_out}, 16'd1);

    // LDI r1=6, r2=1
    issue_ldi(16'hE206);
    chk("ldi1_wb_valid", {15'd0, wb_valid_out}, 16'd1);
    chk("ldi1_wb_addr", {13'd0, wb_addr_out}, 16'd1);
    chk("ldi1_wb_data", wb_data_out, 16'd6);
    dbg("ldi1_dbg1", 3'd1, 16'd6);
    issue_ldi(16'hE401);
    dbg("ldi2_dbg2", 3'd2, 16'd1);

    // op 2: r3 = r1 op r2; a HALT offered during EXEC must be ignored
    bus.instr_in       = 16'h2650;
    bus.instr_valid_in = 1'b1;
    step();
    chk("exec_op", {12'd0, bus.op_code_out}, 16'd2);
    chk("exec_rs1", bus.rs1_out, 16'd6);
    chk("exec_rs2", bus.rs2_out, 16'd1);
    chk("exec_cin", {15'd0, bus.cin_out}, 16'd0);
    chk("exec_bin", {15'd0, bus.bin_out}, 16'd0);
    chk("exec_alu_valid", {15'd0, bus.alu_valid_out}, 16'd1);
    chk("exec_ready", {15'd0, bus.instr_ready_out}, 16'd0);
    bus.instr_in  = 16'hF000;
    bus.result_in = 16'd7;
    step();
    bus.instr_valid_in = 1'b0;
    chk("wb_valid", {15'd0, wb_valid_out}, 16'd1);
    chk("wb_addr", {13'd0, wb_addr_out}, 16'd3);
    chk("wb_data", wb_data_out, 16'd7);
    chk("wb_alu_valid", {15'd0, bus.alu_valid_out}, 16'd0);
    chk("busy_ignored_halt", {15'd0, halted_out}, 16'd0);
    chk("wb_ready", {15'd0, bus.instr_ready_out}, 16'd1);
    dbg("wb_dbg3", 3'd3, 16'd7);

    // r0 write is reported but discarded
    issue_ldi(16'hE005);
    chk("r0_wb_valid", {15'd0, wb_valid_out}, 16'd1);
    chk("r0_wb_addr", {13'd0, wb_addr_out}, 16'd0);
    chk("r0_wb_data", wb_data_out, 16'd5);
    dbg("r0_dbg0", 3'd0, 16'd0);

    // back-to-back: r4 = r3 op r3 with cin, valid held high
    bus.instr_in       = 16'h28DC;
    bus.instr_valid_in = 1'b1;
    bus.result_in      = 16'h0015;
    step();
    chk("b2b_alu_valid1", {15'd0, bus.alu_valid_out}, 16'd1);
    chk("b2b_rs1", bus.rs1_out, 16'd7);
    chk("b2b_rs2", bus.rs2_out, 16'd7);
    chk("b2b_cin", {15'd0, bus.cin_out}, 16'd1);
    step();
    chk("b2b_gap_alu_valid", {15'd0, bus.alu_valid_out}, 16'd0);
    chk("b2b_wb_data1", wb_data_out, 16'h0015);
    step();
    bus.instr_valid_in = 1'b0;
    chk("b2b_alu_valid2", {15'd0, bus.alu_valid_out}, 16'd1);
    chk("b2b_rs1_again", bus.rs1_out, 16'd7);
    bus.result_in = 16'h0020;
    step();
    dbg("b2b_dbg4", 3'd4, 16'h0020);

    // reset mid-EXEC with clock stopped
    bus.instr_in       = 16'h3A52;
    bus.instr_valid_in = 1'b1;
    step();
    bus.instr_valid_in = 1'b0;
    chk("exec2_op", {12'd0, bus.op_code_out}, 16'd3);
    chk("exec2_bin", {15'd0, bus.bin_out}, 16'd1);
    bus.result_in = 16'hABCD;
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_op", {12'd0, bus.op_code_out}, 16'd0);
    chk("rst_rs1", bus.rs1_out, 16'd0);
    chk("rst_rs2", bus.rs2_out, 16'd0);
    chk("rst_cin_bin", {14'd0, bus.cin_out, bus.bin_out}, 16'd0);
    chk("rst_alu_valid", {15'd0, bus.alu_valid_out}, 16'd0);
    chk("rst_wb", {15'd0, wb_valid_out}, 16'd0);
    chk("rst_wb_addr", {13'd0, wb_addr_out}, 16'd0);
    chk("rst_wb_data", wb_data_out, 16'd0);
    chk("rst_halted", {15'd0, halted_out}, 16'd0);
    for (int a = 0; a < 8; a++) dbg($sformatf("rst_dbg%0d", a), 3'(a), 16'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {15'd0, bus.instr_ready_out}, 16'd1);
    clk_en = 1'b1;
    step();
    dbg("rst_abort_dbg5", 3'd5, 16'd0);
    chk("rst_abort_wb", {15'd0, wb_valid_out}, 16'd0);

    // HALT and ignored instructions afterwards
    issue_ldi(16'hE2AB);
    dbg("pre_halt_dbg1", 3'd1, 16'h00AB);
    bus.instr_in       = 16'hF000;
    bus.instr_valid_in = 1'b1;
    step();
    chk("halt_halted", {15'd0, halted_out}, 16'd1);
    chk("halt_ready", {15'd0, bus.instr_ready_out}, 16'd0);
    bus.instr_in = 16'hE2FF;
    step();
    step();
    step();
    bus.instr_valid_in = 1'b0;
    chk("halt_stays", {15'd0, halted_out}, 16'd1);
    chk("halt_no_wb", {15'd0, wb_valid_out}, 16'd0);
    dbg("halt_dbg1", 3'd1, 16'h00AB);
    rst = 1'b1;
    #1;
    chk("halt_rst_cleared", {15'd0, halted_out}, 16'd0);
    rst = 1'b0;
    step();
    chk("halt_rst_ready", {15'd0, bus.instr_ready_out}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage directly upstream of the 16-bit ALU. It accepts one 16-bit instruction word through a valid/ready handshake and decodes it. It reads two operands from an internal 8 x 16 register file, drives the registered op_code, operands and carry/borrow flags into the combinational ALU, and writes the ALU result back to the destination register. Load-immediate and halt are handled locally and never reach the ALU.

## Interface
Parameters:
- NREGS, 8, register count; r0 reads as zero and ignores writes.
- WIDTH, 16, data width (instruction word is fixed at 16 bits).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_in  input  16  instruction word.
- instr_valid_in  input  1  instr_in is valid.
- instr_ready_out  output  1  stage can accept; combinational, equals (state==IDLE).
- op_code_out  output  4  ALU op_code, registered.
- rs1_out  output  16  ALU operand 1, registered.
- rs2_out  output  16  ALU operand 2, registered.
- cin_out  output  1  ALU carry-in, registered.
- bin_out  output  1  ALU borrow-in, registered.
- alu_valid_out  output  1  high for exactly the EXEC cycle of an ALU instruction.
- result_in  input  16  combinational ALU result.
- wb_valid_out  output  1  one-cycle pulse after any register-file write attempt.
- wb_addr_out  output  3  destination of the last write attempt.
- wb_data_out  output  16  data of the last write attempt.
- halted_out  output  1  HALT executed.
- dbg_addr_in  input  3  debug read address.
- dbg_data_out  output  16  combinational read of rf[dbg_addr_in]; returns 0 for address 0.

## Operation
- Encoding:
  - [15:12] op.
  - [11:9] rd.
  - [8:6] rs1.
  - [5:3] rs2.
  - [2] cin.
  - [1] bin.
  - [0] reserved, ignored.
- op 4'hE is LDI: rd <= {7'b0, instr[8:0]}.
- op 4'hF is HALT.
- Every other op is forwarded to the ALU unchanged.
- FSM states:
  - IDLE: the stage accepts when instr_valid_in is high.
    - ALU op goes to EXEC.
    - LDI goes to LDI_WB.
    - HALT goes to HALT.
  - EXEC: alu_valid_out=1. At the edge leaving EXEC, result_in is written to rf[rd], then the FSM returns to IDLE.
  - LDI_WB: the immediate is written to rf[rd], then the FSM returns to IDLE. alu_valid_out stays 0.
  - HALT: halted_out=1 and instr_ready_out=0. Only rst leaves this state.
- At the accept edge, op_code_out/rs1_out/rs2_out/cin_out/bin_out load {op, rf[rs1], rf[rs2], cin, bin}. They hold until the next ALU accept; LDI and HALT do not change them.
- Writes to rd=0 are discarded. They still pulse wb_valid_out, with wb_addr_out=0 and wb_data_out set to the discarded value.
- No bypass is needed. instr_ready_out is low in EXEC and LDI_WB, so a dependent instruction reads the register file at least one edge after the producing write.
- rs1==rs2 is legal; both operand outputs carry the same value.

## Timing
- Reset (async, immediate):
  - FSM goes to IDLE.
  - All register-file entries clear to 0.
  - Every output register clears to 0: op_code_out, rs1_out, rs2_out, cin_out, bin_out, alu_valid_out, wb_valid_out, wb_addr_out, wb_data_out, halted_out.
  - instr_ready_out=1 once rst deasserts.
- Reset during EXEC or LDI_WB aborts the instruction; no register-file write occurs.
- ALU op, accepted at edge N:
  - Cycle N..N+1: alu_valid_out=1 with operands stable.
  - Edge N+1: result_in is sampled and the register file is written.
  - Cycle N+1..N+2: wb_valid_out=1 and instr_ready_out=1.
  - The next accept is possible at edge N+2, so throughput is one instruction per 2 cycles.
- LDI follows the same timing with alu_valid_out=0.
- HALT, accepted at edge N: halted_out=1 from N onward.
- instr_valid_in while instr_ready_out=0 is ignored; the sender must hold the word.

## Test plan
- Reset:
  - Stimulus: assert rst mid-cycle with the clock stopped.
  - Required response: all outputs go to 0 immediately, dbg_data_out=0 for every address, and instr_ready_out=1 after release.
- LDI then ALU op:
  - Stimulus: issue 16'hE206 (r1=6), 16'hE401 (r2=1), then 16'h2650 (op 2, r3=r1,r2).
  - Required response in the EXEC cycle: op_code_out=2, rs1_out=6, rs2_out=1, cin_out=0, bin_out=0, alu_valid_out=1.
  - With the bench driving result_in=7: next cycle wb_valid_out=1, wb_addr_out=3, wb_data_out=7, and dbg(3)=7.
- r0 write:
  - Stimulus: LDI r0,5 (16'hE005).
  - Required response: wb_valid_out pulses with data 5, and dbg(0) remains 0.
- Back-to-back dependency:
  - Stimulus: after r3=7, issue op 2 with rs1=r3, rs2=r3, holding instr_valid_in high.
  - Required response: accepts occur exactly 2 cycles apart, and rs1_out=rs2_out=7.
- Handshake/HALT:
  - Stimulus 1: drive instr_valid_in high during EXEC. Required response: no accept.
  - Stimulus 2: issue 16'hF000. Required response: halted_out=1, instr_ready_out=0, and later instructions are ignored until rst.
- Reset mid-EXEC:
  - Stimulus: assert rst in the EXEC cycle with result_in=16'hABCD.
  - Required response: no write occurs and dbg(rd)=0.
